// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path types and widths
//
// Purpose: common sample width, PCM sample type and the SPI receiver
// state encoding used by the audio front end.
// Ports: none (package).

package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_rx_state_t;

  typedef logic signed [AUDIO_W-1:0] pcm_t;

endpackage

// File: rtl/spi_sample_deserializer_if.sv
// rtl/spi_sample_deserializer_if.sv - SPI pins and sample outputs of the audio front end
//
// Purpose: bundles the external SPI pins and the sample-side outputs.
// Signals:
//   spi_sclk, spi_cs_n, spi_mosi : SPI mode 0 pins driven by the ADC (master)
//   sample_out                   : last accepted sample, two's complement
//   sample_valid                 : 1-cycle pulse on a new sample
//   frame_error                  : 1-cycle pulse on a bad-length frame
//   link_stale                   : no valid frame for the timeout period
// Modports: master = ADC side / stimulus, slave = deserializer.

interface spi_sample_deserializer_if
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W
) ();

  logic                     spi_sclk;
  logic                     spi_cs_n;
  logic                     spi_mosi;
  logic signed [DATA_W-1:0] sample_out;
  logic                     sample_valid;
  logic                     frame_error;
  logic                     link_stale;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  sample_out, sample_valid, frame_error, link_stale
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output sample_out, sample_valid, frame_error, link_stale
  );

endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - pin synchronizer with registered rise/fall pulses
//
// Purpose: brings an asynchronous pin into the clk domain and produces
// one-cycle edge pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level, time-aligned with rise/fall
//   rise, fall : registered 1-cycle edge pulses

module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              lvl_q;
  logic              lvl_d;

  // Synchronizer chain, then one registered level and its delayed copy.
  // Edge pulses are themselves registered, so level is taken from lvl_d,
  // which updates on the same edge as rise/fall; a data pin using only
  // level therefore lines up with another pin's edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      lvl_d  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      lvl_q  <= sync_q[STAGES-1];
      lvl_d  <= lvl_q;
      rise   <= lvl_q & ~lvl_d;
      fall   <= ~lvl_q & lvl_d;
    end
  end

  assign level = lvl_d;

endmodule

// File: rtl/spi_sample_deserializer.sv
// rtl/spi_sample_deserializer.sv - oversampled SPI slave receiving one PCM sample per frame
//
// Purpose: receives one DATA_W-bit MSB-first sample per chip-select frame,
// validates the frame length, holds the last good sample, flags a stalled
// link and optionally mutes the output while stalled.
// Ports:
//   input_clk : system clock, all logic on posedge
//   reset_n   : asynchronous active-low reset
//   bus       : slave modport (SPI pins in; sample_out, sample_valid,
//               frame_error, link_stale out)

module spi_sample_deserializer
  import audio_pkg::*;
#(
  parameter int DATA_W         = AUDIO_W,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MUTE_ON_STALE  = 1
) (
  input  logic                       input_clk,
  input  logic                       reset_n,
  spi_sample_deserializer_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  logic sclk_rise, sclk_fall_unused, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(input_clk), .rst_n(reset_n), .din(bus.spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(input_clk), .rst_n(reset_n), .din(bus.spi_cs_n),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(input_clk), .rst_n(reset_n), .din(bus.spi_mosi),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_rx_state_t     state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              frame_ok, frame_bad;

  logic [TO_W-1:0]   timeout_cnt;
  logic [DATA_W-1:0] sample_q;
  logic              valid_q, error_q, stale_q;

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  // A frame only starts on a seen cs_n falling edge, so a cs_n that is
  // already low when reset releases is ignored until it goes high again.
  // When the last sclk rise and cs_n rise coincide, the bit is counted
  // first and the frame is judged on the updated count and shift value.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_n = {shift[DATA_W-2:0], mosi};
          // Saturate one past full so an over-long frame cannot wrap
          // back onto a valid-looking count.
          if (bit_cnt != CNT_SAT) begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        if (cs_rise) begin
          state_n = IDLE;
          if (bit_cnt_n == CNT_FULL) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // link_stale comes out of reset high (nothing received yet) and is only
  // released by a valid frame; otherwise it tracks the saturated counter.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q    <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      stale_q     <= 1'b1;
      timeout_cnt <= '0;
    end else begin
      valid_q <= frame_ok;
      error_q <= frame_bad;
      if (frame_ok) begin
        sample_q    <= shift_n;
        timeout_cnt <= '0;
        stale_q     <= 1'b0;
      end else begin
        if (timeout_cnt != TO_MAX) begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
        if (timeout_cnt == TO_MAX) begin
          stale_q <= 1'b1;
        end
        if ((MUTE_ON_STALE != 0) && stale_q) begin
          sample_q <= '0;
        end
      end
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_error  = error_q;
  assign bus.link_stale   = stale_q;

endmodule
